// File: rtl/id_issue_align_if.sv
// IB -> issue-align -> decode boundary signals. master = IB/decode side, slave = id_issue_align.
interface id_issue_align_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int PTAB_W = 5
);
  logic              flush;
  logic [ADDR_W-1:0] ib_id_pc_0, ib_id_pc_1;
  logic [INSN_W-1:0] ib_id_insn_0, ib_id_insn_1;
  logic [PTAB_W-1:0] ib_id_ptab_addr_0, ib_id_ptab_addr_1;
  logic              ib_id_valid_0, ib_id_valid_1;
  logic              ib_valid_ns;
  logic              id_allin;
  logic              ex_allin;
  logic [ADDR_W-1:0] id_pc_0, id_pc_1;
  logic [INSN_W-1:0] id_insn_0, id_insn_1;
  logic [PTAB_W-1:0] id_ptab_addr_0, id_ptab_addr_1;
  logic              id_valid_0, id_valid_1, id_valid_ns;

  modport master (
    output flush, ib_id_pc_0, ib_id_pc_1, ib_id_insn_0, ib_id_insn_1,
           ib_id_ptab_addr_0, ib_id_ptab_addr_1, ib_id_valid_0, ib_id_valid_1,
           ib_valid_ns, ex_allin,
    input  id_allin, id_pc_0, id_pc_1, id_insn_0, id_insn_1,
           id_ptab_addr_0, id_ptab_addr_1, id_valid_0, id_valid_1, id_valid_ns
  );

  modport slave (
    input  flush, ib_id_pc_0, ib_id_pc_1, ib_id_insn_0, ib_id_insn_1,
           ib_id_ptab_addr_0, ib_id_ptab_addr_1, ib_id_valid_0, ib_id_valid_1,
           ib_valid_ns, ex_allin,
    output id_allin, id_pc_0, id_pc_1, id_insn_0, id_insn_1,
           id_ptab_addr_0, id_ptab_addr_1, id_valid_0, id_valid_1, id_valid_ns
  );
endinterface

// File: rtl/id_issue_align.sv
// Compacts the IB two-slot group and registers up to two instructions toward decode.
// DELAY_SLOT_PAIR_EN: keep every branch/jump in the same issue group as its delay slot.
module id_issue_align #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter int PTAB_W = 5
) (
  input  logic clk,
  input  logic rst_,
  id_issue_align_if.slave bus
);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSN_W-1:0] insn;
    logic [PTAB_W-1:0] ptab;
  } ent_t;

  ent_t       r_carry0, r_carry1, r_out0, r_out1;
  logic [1:0] r_carry_cnt;
  logic       r_v0, r_v1;

  ent_t       w_slot0, w_slot1, w_in0, w_s0, w_s1, w_s2, w_nxt0, w_nxt1;
  logic [1:0] w_n_in, w_len, w_n_iss, w_cnt_nxt;
  logic       w_adv, w_allin, w_accept, w_br0, w_br1;

`ifdef DELAY_SLOT_PAIR_EN
  function automatic logic is_br(input logic [INSN_W-1:0] insn);
    logic [5:0] op, funct;
    logic [4:0] rt;
    op    = insn[31:26];
    rt    = insn[20:16];
    funct = insn[5:0];
    is_br = (op inside {6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110, 6'b000111}) ||
            (op == 6'b000001 && (rt inside {5'b00000, 5'b00001, 5'b10000, 5'b10001})) ||
            (op == 6'b000000 && (funct inside {6'b001000, 6'b001001}));
  endfunction
  assign w_br0 = is_br(w_s0.insn);
  assign w_br1 = is_br(w_s1.insn);
`else
  assign w_br0 = 1'b0;
  assign w_br1 = 1'b0;
`endif

  assign w_adv    = !r_v0 || bus.ex_allin;
  assign w_allin  = w_adv && (r_carry_cnt < 2'd2) && !bus.flush && !rst_;
  assign w_accept = bus.ib_valid_ns && w_allin;

  assign w_slot0 = '{pc: bus.ib_id_pc_0, insn: bus.ib_id_insn_0, ptab: bus.ib_id_ptab_addr_0};
  assign w_slot1 = '{pc: bus.ib_id_pc_1, insn: bus.ib_id_insn_1, ptab: bus.ib_id_ptab_addr_1};
  // A lone slot1 entry slides into entry 0; entry 1 is only meaningful when both are valid.
  assign w_in0  = bus.ib_id_valid_0 ? w_slot0 : w_slot1;
  assign w_n_in = {1'b0, bus.ib_id_valid_0} + {1'b0, bus.ib_id_valid_1};
  assign w_len  = r_carry_cnt + (w_accept ? w_n_in : 2'd0);

  always_comb begin
    w_s0 = '0;
    w_s1 = '0;
    w_s2 = '0;
    case (r_carry_cnt)
      2'd0:    begin w_s0 = w_in0;    w_s1 = w_slot1; end
      2'd1:    begin w_s0 = r_carry0; w_s1 = w_in0;    w_s2 = w_slot1; end
      default: begin w_s0 = r_carry0; w_s1 = r_carry1; end
    endcase
  end

  always_comb begin
    w_n_iss = 2'd0;
    if (w_len == 2'd1)      w_n_iss = w_br0 ? 2'd0 : 2'd1;
    else if (w_len >= 2'd2) w_n_iss = w_br1 ? 2'd1 : 2'd2;
  end

  always_comb begin
    w_nxt0 = w_s0;
    w_nxt1 = w_s1;
    case (w_n_iss)
      2'd1:    begin w_nxt0 = w_s1; w_nxt1 = w_s2; end
      2'd2:    begin w_nxt0 = w_s2; w_nxt1 = '0;   end
      default: ;
    endcase
  end
  assign w_cnt_nxt = w_len - w_n_iss;

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_carry0    <= '0;
      r_carry1    <= '0;
      r_carry_cnt <= 2'd0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
    end else if (bus.flush) begin
      r_carry_cnt <= 2'd0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
    end else if (w_adv) begin
      r_carry0    <= w_nxt0;
      r_carry1    <= w_nxt1;
      r_carry_cnt <= w_cnt_nxt;
      r_out0      <= w_s0;
      r_out1      <= w_s1;
      r_v0        <= (w_n_iss != 2'd0);
      r_v1        <= (w_n_iss == 2'd2);
    end
  end

  assign bus.id_allin       = w_allin;
  assign bus.id_pc_0        = r_out0.pc;
  assign bus.id_pc_1        = r_out1.pc;
  assign bus.id_insn_0      = r_out0.insn;
  assign bus.id_insn_1      = r_out1.insn;
  assign bus.id_ptab_addr_0 = r_out0.ptab;
  assign bus.id_ptab_addr_1 = r_out1.ptab;
  assign bus.id_valid_0     = r_v0;
  assign bus.id_valid_1     = r_v1;
  assign bus.id_valid_ns    = r_v0;
endmodule

// File: tb/tb_id_issue_align.sv
// Directed bench for id_issue_align; expectations follow whichever DELAY_SLOT_PAIR_EN build is compiled.
module tb_id_issue_align;
  localparam logic [31:0] ALU = 32'h00221820;
  localparam logic [31:0] BEQ = 32'h10000003;
  localparam logic [31:0] JR  = 32'h03E00008;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  id_issue_align_if bus ();
  id_issue_align dut (.clk(clk), .rst_(rst_), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] pc0, input logic [31:0] i0,
                       input logic [31:0] pc1, input logic [31:0] i1);
    bus.ib_valid_ns       = 1'b1;
    bus.ib_id_valid_0     = v0;
    bus.ib_id_valid_1     = v1;
    bus.ib_id_pc_0        = pc0;
    bus.ib_id_pc_1        = pc1;
    bus.ib_id_insn_0      = i0;
    bus.ib_id_insn_1      = i1;
    bus.ib_id_ptab_addr_0 = {1'b1, pc0[5:2]};
    bus.ib_id_ptab_addr_1 = {1'b1, pc1[5:2]};
  endtask

  task automatic test_reset();
    bus.flush = 1'b0; bus.ex_allin = 1'b1;
    drive(1'b1, 1'b1, 32'h1000, ALU, 32'h1004, ALU);
    step(); step();
    n_chk++; if (bus.id_valid_0 !== 1'b0) begin n_err++; $display("FAIL rst_v0 got %b exp 0", bus.id_valid_0); end
    n_chk++; if (bus.id_valid_1 !== 1'b0) begin n_err++; $display("FAIL rst_v1 got %b exp 0", bus.id_valid_1); end
    n_chk++; if (bus.id_pc_0 !== 32'h0) begin n_err++; $display("FAIL rst_pc0 got %h exp 0", bus.id_pc_0); end
    n_chk++; if (bus.id_allin !== 1'b0) begin n_err++; $display("FAIL rst_allin got %b exp 0", bus.id_allin); end
    n_chk++; if (dut.r_carry_cnt !== 2'd0) begin n_err++; $display("FAIL rst_carry got %0d exp 0", dut.r_carry_cnt); end
    rst_ = 1'b0;
  endtask

  task automatic test_basic();
    drive(1'b1, 1'b1, 32'h1000, ALU, 32'h1004, ALU);
    step();
    n_chk++; if (bus.id_pc_0 !== 32'h1000) begin n_err++; $display("FAIL basic_pc0 got %h exp 1000", bus.id_pc_0); end
    n_chk++; if (bus.id_pc_1 !== 32'h1004) begin n_err++; $display("FAIL basic_pc1 got %h exp 1004", bus.id_pc_1); end
    n_chk++; if ({bus.id_valid_0, bus.id_valid_1, bus.id_valid_ns} !== 3'b111) begin n_err++; $display("FAIL basic_valid got %b%b%b exp 111", bus.id_valid_0, bus.id_valid_1, bus.id_valid_ns); end
    n_chk++; if (bus.id_ptab_addr_1 !== 5'h11) begin n_err++; $display("FAIL basic_ptab1 got %h exp 11", bus.id_ptab_addr_1); end
    n_chk++; if (bus.id_insn_0 !== ALU) begin n_err++; $display("FAIL basic_insn0 got %h exp %h", bus.id_insn_0, ALU); end
    n_chk++; if (dut.r_carry_cnt !== 2'd0) begin n_err++; $display("FAIL basic_carry got %0d exp 0", dut.r_carry_cnt); end
  endtask

  task automatic test_slot1_only();
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h2004, ALU);
    step();
    n_chk++; if (bus.id_pc_0 !== 32'h2004) begin n_err++; $display("FAIL s1only_pc0 got %h exp 2004", bus.id_pc_0); end
    n_chk++; if ({bus.id_valid_0, bus.id_valid_1} !== 2'b10) begin n_err++; $display("FAIL s1only_valid got %b%b exp 10", bus.id_valid_0, bus.id_valid_1); end
    n_chk++; if (bus.id_ptab_addr_0 !== 5'h11) begin n_err++; $display("FAIL s1only_ptab0 got %h exp 11", bus.id_ptab_addr_0); end
  endtask

  task automatic test_branch_pair();
    logic [31:0] e_pc0;
    logic [1:0]  e_v, e_c;
    drive(1'b1, 1'b1, 32'h3000, ALU, 32'h3004, BEQ);
    step();
`ifdef DELAY_SLOT_PAIR_EN
    e_v = 2'b10; e_c = 2'd1;
`else
    e_v = 2'b11; e_c = 2'd0;
`endif
    n_chk++; if (bus.id_pc_0 !== 32'h3000) begin n_err++; $display("FAIL br1_pc0 got %h exp 3000", bus.id_pc_0); end
    n_chk++; if ({bus.id_valid_0, bus.id_valid_1} !== e_v) begin n_err++; $display("FAIL br1_valid got %b%b exp %b", bus.id_valid_0, bus.id_valid_1, e_v); end
    n_chk++; if (dut.r_carry_cnt !== e_c) begin n_err++; $display("FAIL br1_carry got %0d exp %0d", dut.r_carry_cnt, e_c); end
    drive(1'b1, 1'b1, 32'h3008, ALU, 32'h300C, ALU);
    step();
`ifdef DELAY_SLOT_PAIR_EN
    e_pc0 = 32'h3004; e_c = 2'd1;
`else
    e_pc0 = 32'h3008; e_c = 2'd0;
`endif
    n_chk++; if (bus.id_pc_0 !== e_pc0) begin n_err++; $display("FAIL br2_pc0 got %h exp %h", bus.id_pc_0, e_pc0); end
    n_chk++; if (bus.id_pc_1 !== e_pc0 + 32'h4) begin n_err++; $display("FAIL br2_pc1 got %h exp %h", bus.id_pc_1, e_pc0 + 32'h4); end
    n_chk++; if (dut.r_carry_cnt !== e_c) begin n_err++; $display("FAIL br2_carry got %0d exp %0d", dut.r_carry_cnt, e_c); end
  endtask

  task automatic test_stall();
    logic [31:0] e_pc0;
    logic [1:0]  e_c;
    drive(1'b1, 1'b1, 32'h3010, BEQ, 32'h3014, ALU);
    step();
`ifdef DELAY_SLOT_PAIR_EN
    e_pc0 = 32'h300C; e_c = 2'd2;
    n_chk++; if (bus.id_allin !== 1'b0) begin n_err++; $display("FAIL stall_full_allin got %b exp 0", bus.id_allin); end
`else
    e_pc0 = 32'h3010; e_c = 2'd0;
`endif
    n_chk++; if (dut.r_carry_cnt !== e_c) begin n_err++; $display("FAIL stall_carry got %0d exp %0d", dut.r_carry_cnt, e_c); end
    bus.ex_allin = 1'b0;
    drive(1'b1, 1'b1, 32'h3018, ALU, 32'h301C, ALU);
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++; if (bus.id_allin !== 1'b0) begin n_err++; $display("FAIL stall_allin[%0d] got %b exp 0", k, bus.id_allin); end
      n_chk++; if (bus.id_pc_0 !== e_pc0 || bus.id_valid_0 !== 1'b1) begin n_err++; $display("FAIL stall_hold[%0d] got %h/%b exp %h/1", k, bus.id_pc_0, bus.id_valid_0, e_pc0); end
    end
    bus.ex_allin = 1'b1;
    step();
`ifdef DELAY_SLOT_PAIR_EN
    n_chk++; if (bus.id_pc_0 !== 32'h3010 || bus.id_pc_1 !== 32'h3014 || bus.id_valid_1 !== 1'b1) begin n_err++; $display("FAIL drain_pair got %h/%h/%b exp 3010/3014/1", bus.id_pc_0, bus.id_pc_1, bus.id_valid_1); end
    n_chk++; if (bus.id_allin !== 1'b1) begin n_err++; $display("FAIL drain_allin got %b exp 1", bus.id_allin); end
    step();
`endif
    n_chk++; if (bus.id_pc_0 !== 32'h3018 || bus.id_pc_1 !== 32'h301C) begin n_err++; $display("FAIL stall_resume got %h/%h exp 3018/301c", bus.id_pc_0, bus.id_pc_1); end
  endtask

  task automatic test_lone_branch();
    drive(1'b1, 1'b0, 32'h4000, JR, 32'h0, 32'h0);
    step();
`ifdef DELAY_SLOT_PAIR_EN
    n_chk++; if (bus.id_valid_0 !== 1'b0) begin n_err++; $display("FAIL lone_wait got %b exp 0", bus.id_valid_0); end
`else
    n_chk++; if (bus.id_valid_0 !== 1'b1 || bus.id_pc_0 !== 32'h4000) begin n_err++; $display("FAIL lone_issue got %b/%h exp 1/4000", bus.id_valid_0, bus.id_pc_0); end
`endif
    drive(1'b1, 1'b0, 32'h4004, ALU, 32'h0, 32'h0);
    step();
`ifdef DELAY_SLOT_PAIR_EN
    n_chk++; if (bus.id_pc_0 !== 32'h4000 || bus.id_pc_1 !== 32'h4004 || bus.id_valid_1 !== 1'b1) begin n_err++; $display("FAIL lone_pair got %h/%h/%b exp 4000/4004/1", bus.id_pc_0, bus.id_pc_1, bus.id_valid_1); end
`else
    n_chk++; if (bus.id_pc_0 !== 32'h4004 || bus.id_valid_1 !== 1'b0) begin n_err++; $display("FAIL lone_next got %h/%b exp 4004/0", bus.id_pc_0, bus.id_valid_1); end
`endif
  endtask

  task automatic test_flush();
`ifdef DELAY_SLOT_PAIR_EN
    drive(1'b1, 1'b0, 32'h6000, BEQ, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 32'h6004, BEQ, 32'h6008, ALU);
    step();
    n_chk++; if (dut.r_carry_cnt !== 2'd2 || bus.id_pc_0 !== 32'h6000 || bus.id_valid_0 !== 1'b1) begin n_err++; $display("FAIL preflush got %0d/%h/%b exp 2/6000/1", dut.r_carry_cnt, bus.id_pc_0, bus.id_valid_0); end
`else
    drive(1'b1, 1'b1, 32'h6000, ALU, 32'h6004, ALU);
    step();
    n_chk++; if (bus.id_valid_0 !== 1'b1) begin n_err++; $display("FAIL preflush got %b exp 1", bus.id_valid_0); end
`endif
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, 32'h7000, ALU, 32'h7004, ALU);
    #1;
    n_chk++; if (bus.id_allin !== 1'b0) begin n_err++; $display("FAIL flush_allin got %b exp 0", bus.id_allin); end
    step();
    bus.flush = 1'b0;
    #1;
    n_chk++; if ({bus.id_valid_0, bus.id_valid_1, bus.id_valid_ns} !== 3'b000) begin n_err++; $display("FAIL flush_valid got %b%b%b exp 000", bus.id_valid_0, bus.id_valid_1, bus.id_valid_ns); end
    n_chk++; if (dut.r_carry_cnt !== 2'd0) begin n_err++; $display("FAIL flush_carry got %0d exp 0", dut.r_carry_cnt); end
    n_chk++; if (bus.id_allin !== 1'b1) begin n_err++; $display("FAIL flush_reallin got %b exp 1", bus.id_allin); end
    step();
    n_chk++; if (bus.id_pc_0 !== 32'h7000 || bus.id_pc_1 !== 32'h7004 || bus.id_valid_1 !== 1'b1) begin n_err++; $display("FAIL postflush got %h/%h/%b exp 7000/7004/1", bus.id_pc_0, bus.id_pc_1, bus.id_valid_1); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 32'h8000, ALU, 32'h8004, ALU);
    step();
    #2;
    rst_ = 1'b1;
    #1;
    n_chk++; if (bus.id_valid_0 !== 1'b0 || bus.id_pc_0 !== 32'h0) begin n_err++; $display("FAIL midrst_out got %b/%h exp 0/0", bus.id_valid_0, bus.id_pc_0); end
    n_chk++; if (bus.id_allin !== 1'b0) begin n_err++; $display("FAIL midrst_allin got %b exp 0", bus.id_allin); end
    step();
    rst_ = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_slot1_only();
    test_branch_pair();
    test_stall();
    test_lone_branch();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
